lsu_mem_stage: RTL and testbench

//  Load/store stage directly downstream of the ALU: alu_result is the effective address.

---
 rtl/lsu_mem_stage.sv | 82 ++++++++
 tb/tb_lsu_mem_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: turns one load/store into a single valid/ready word request on the data-memory port
module lsu_mem_stage #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  input  logic           req_we,
  input  logic [2:0]     req_funct3,
  input  logic [LEN-1:0] alu_result,
  input  logic [LEN-1:0] store_data,
  output logic           req_ready,
  output logic           stall,
  output logic           mem_req_valid,
  input  logic           mem_req_ready,
  output logic [LEN-1:0] mem_addr,
  output logic           mem_we,
  output logic [3:0]     mem_wstrb,
  output logic [LEN-1:0] mem_wdata,
  input  logic           mem_rsp_valid,
  input  logic [LEN-1:0] mem_rdata,
  output logic [LEN-1:0] load_data,
  output logic           done,
  output logic           fault
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;
  state_t state, state_nx;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [1:0] off;
  logic illegal;
  logic [3:0] strb;
  logic [LEN-1:0] wdata_c, lane, ext;
  assign off = alu_result[1:0];
  // size code 11 is never legal; loads may use bit 2 only as the unsigned flag for bytes/halves
  assign illegal = (&req_funct3[1:0]) | (req_funct3[2] & (req_we | req_funct3[1]))
                 | (req_funct3[1:0] == 2'b01 & off[0]) | (req_funct3[1:0] == 2'b10 & |off);
  assign strb = req_funct3[1:0] == 2'b00 ? 4'b0001 << off :
                req_funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign wdata_c = req_funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                   req_funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  assign lane = mem_rdata >> {off_q, 3'b000};
  assign ext = f3_q[1:0] == 2'b00 ? {{(LEN-8){~f3_q[2] & lane[7]}}, lane[7:0]} :
               f3_q[1:0] == 2'b01 ? {{(LEN-16){~f3_q[2] & lane[15]}}, lane[15:0]} : lane;
  assign req_ready = state == IDLE;
  assign mem_req_valid = state == REQ;
  assign done = state == DONE;
  assign fault = state == FAULT;
  assign stall = (state == IDLE & req_valid) | state == REQ | state == WAIT;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (illegal ? FAULT : REQ) : IDLE;
      REQ:     state_nx = mem_req_ready ? (mem_we ? DONE : WAIT) : REQ;
      WAIT:    state_nx = mem_rsp_valid ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      load_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid && !illegal) begin
        mem_addr  <= {alu_result[LEN-1:2], 2'b00};
        mem_we    <= req_we;
        mem_wstrb <= req_we ? strb : 4'b0000;
        mem_wdata <= req_we ? wdata_c : '0;
        f3_q      <= req_funct3;
        off_q     <= off;
      end
      if (state == WAIT && mem_rsp_valid) load_data <= ext;
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: scoreboard bench for the load/store memory stage
module tb_lsu_mem_stage;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] alu_result = 0, store_data = 0, mem_rdata = 0;
  logic mem_req_ready = 0, mem_rsp_valid = 0;
  logic req_ready, stall, mem_req_valid, mem_we, done, fault;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, load_data;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata;} req_t;
  typedef struct packed {logic ld; logic [31:0] data;} done_t;
  req_t exp_req[$];
  done_t exp_done[$];

  lsu_mem_stage #(.LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .alu_result(alu_result), .store_data(store_data), .req_ready(req_ready), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .load_data(load_data), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int size_of(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic model_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    bad = we ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    if (size_of(f3) == 2 && a[0]) bad = 1;
    if (size_of(f3) == 4 && a[1:0] != 2'b00) bad = 1;
    return bad;
  endfunction

  function automatic req_t model_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    req_t r;
    int sz, off;
    sz = size_of(f3);
    off = int'(a[1:0]);
    r = '0;
    r.addr = a & 32'hFFFF_FFFC;
    r.we = we;
    for (int i = 0; i < 4; i++) begin
      if (we && i >= off && i < off + sz) r.strb[i] = 1'b1;
      r.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int sz, off;
    sz = size_of(f3);
    off = int'(a[1:0]);
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz - 1])
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // scoreboard: every handshake and every done pulse is checked against the queued expectation
  always @(negedge clk) begin
    if (rst_n && mem_req_valid && mem_req_ready) begin
      req_t e;
      vectors++;
      if (exp_req.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_req: got addr %h, want no request", mem_addr);
      end else begin
        e = exp_req.pop_front();
        if (mem_addr !== e.addr || mem_we !== e.we || mem_wstrb !== e.strb || (e.we && mem_wdata !== e.wdata)) begin
          miscompares++;
          $display("FAIL mem_req: got addr %h we %b strb %b wdata %h, want addr %h we %b strb %b wdata %h",
                   mem_addr, mem_we, mem_wstrb, mem_wdata, e.addr, e.we, e.strb, e.wdata);
        end
      end
    end
    if (rst_n && done) begin
      done_t d;
      vectors++;
      if (exp_done.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done 1, want 0");
      end else begin
        d = exp_done.pop_front();
        if (d.ld && load_data !== d.data) begin
          miscompares++;
          $display("FAIL load_data: got %h, want %h", load_data, d.data);
        end
      end
    end
  end

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input int rdly, input int rspdly, input int lat);
    logic bad, fin, hs, first;
    int nreq, wc, c_end;
    logic [68:0] snap;
    bad = model_illegal(we, f3, addr);
    if (!bad) begin
      exp_req.push_back(model_req(we, f3, addr, sd));
      exp_done.push_back({!we, model_load(f3, addr, rdata)});
    end
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_funct3 = f3; alu_result = addr; store_data = sd; mem_rdata = rdata;
    mem_req_ready = (rdly == 0); mem_rsp_valid = 0;
    fin = 0; hs = 0; first = 1; nreq = 0; wc = 0; c_end = -1; snap = '0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      vectors++;
      if (done || fault) begin
        fin = 1; c_end = c;
        if (fault !== bad || done !== !bad) begin
          miscompares++;
          $display("FAIL completion_kind: got done %b fault %b, want fault %b", done, fault, bad);
        end
      end else if (stall !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_busy: got %b at cycle %0d, want 1", stall, c);
      end
      if (mem_req_valid) begin
        if (bad) begin
          vectors++; miscompares++;
          $display("FAIL req_on_fault: got mem_req_valid 1, want 0");
        end
        if (first) begin
          snap = {mem_addr, mem_we, mem_wstrb, mem_wdata}; first = 0;
        end else begin
          vectors++;
          if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== snap) begin
            miscompares++;
            $display("FAIL mem_stable: got %h, want %h", {mem_addr, mem_we, mem_wstrb, mem_wdata}, snap);
          end
        end
        if (mem_req_ready) hs = 1; else nreq++;
      end
      @(posedge clk); #1;
      if (fin) begin
        req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
      end else begin
        mem_req_ready = nreq >= rdly;
        if (hs && !we) begin
          mem_rsp_valid = wc >= rspdly; wc++;
        end
      end
    end
    if (!fin) begin
      vectors++; miscompares++;
      $display("FAIL timeout: got no done/fault in 40 cycles, want completion");
    end
    if (lat >= 0) begin
      vectors++;
      if (c_end != lat) begin
        miscompares++;
        $display("FAIL latency: got %0d, want %0d", c_end, lat);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 0 || fault !== 0 || stall !== 0 || mem_req_valid !== 0 || req_ready !== 1) begin
      miscompares++;
      $display("FAIL after_op: got done %b fault %b stall %b mreq %b ready %b, want 0 0 0 0 1",
               done, fault, stall, mem_req_valid, req_ready);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    vectors++;
    if (req_ready !== 1 || stall !== 0 || mem_req_valid !== 0 || mem_addr !== 0 || mem_we !== 0 ||
        mem_wstrb !== 0 || mem_wdata !== 0 || load_data !== 0 || done !== 0 || fault !== 0) begin
      miscompares++;
      $display("FAIL %s: got ready %b stall %b mreq %b addr %h we %b strb %b wdata %h ld %h done %b fault %b, want ready 1 rest 0",
               tag, req_ready, stall, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, load_data, done, fault);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset_hold");
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check_idle_zero("reset_release");
  endtask

  task automatic test_stores();
    run_op(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 2);
    vectors++;
    if (mem_wstrb !== 4'b1111 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL sw_fields: got strb %b wdata %h addr %h, want 1111 deadbeef 00000100", mem_wstrb, mem_wdata, mem_addr);
    end
    run_op(1, 3'b000, 32'h103, 32'h000000AB, 0, 0, 0, 2);
    vectors++;
    if (mem_wstrb !== 4'b1000 || mem_wdata !== 32'hABABABAB || mem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL sb_fields: got strb %b wdata %h addr %h, want 1000 abababab 00000100", mem_wstrb, mem_wdata, mem_addr);
    end
    run_op(1, 3'b001, 32'h202, 32'h1234CAFE, 0, 1, 0, 3);
  endtask

  task automatic test_loads();
    run_op(0, 3'b000, 32'h102, 0, 32'h12F45678, 0, 0, 3);
    vectors++;
    if (load_data !== 32'hFFFFFFF4) begin
      miscompares++;
      $display("FAIL lb_value: got %h, want fffffff4", load_data);
    end
    run_op(0, 3'b100, 32'h102, 0, 32'h12F45678, 0, 0, 3);
    vectors++;
    if (load_data !== 32'h000000F4) begin
      miscompares++;
      $display("FAIL lbu_value: got %h, want 000000f4", load_data);
    end
    run_op(0, 3'b001, 32'h102, 0, 32'h8001ABCD, 0, 0, 3);
    run_op(0, 3'b101, 32'h102, 0, 32'h8001ABCD, 0, 0, 3);
    run_op(0, 3'b010, 32'h104, 0, 32'hCAFEF00D, 0, 1, 4);
  endtask

  task automatic test_faults();
    run_op(0, 3'b010, 32'h102, 0, 0, 0, 0, 1);
    run_op(0, 3'b011, 32'h100, 0, 0, 0, 0, 1);
    run_op(1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 1);
    run_op(0, 3'b001, 32'h101, 0, 0, 0, 0, 1);
    run_op(1, 3'b010, 32'h101, 32'h1, 0, 0, 0, 1);
  endtask

  task automatic test_stall_hold();
    run_op(0, 3'b001, 32'h200, 0, 32'h0000F00F, 3, 2, 8);
    vectors++;
    if (load_data !== 32'hFFFFF00F) begin
      miscompares++;
      $display("FAIL lh_held_value: got %h, want fffff00f", load_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), -1);
  endtask

  task automatic test_reset_mid();
    exp_req.push_back(model_req(0, 3'b010, 32'h300, 0));
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; alu_result = 32'h300; mem_req_ready = 1; mem_rsp_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    mem_req_ready = 0;
    @(negedge clk);
    vectors++;
    if (stall !== 1 || mem_req_valid !== 0) begin
      miscompares++;
      $display("FAIL wait_state: got stall %b mreq %b, want 1 0", stall, mem_req_valid);
    end
    @(posedge clk); #1;
    rst_n = 0; req_valid = 0;
    @(negedge clk);
    check_idle_zero("reset_mid_op");
    @(posedge clk); #1;
    rst_n = 1; mem_rsp_valid = 1; mem_rdata = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle_zero("late_rsp_ignored");
    end
    @(posedge clk); #1;
    mem_rsp_valid = 0;
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_faults();
    test_stall_hold();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (exp_req.size() != 0 || exp_done.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d reqs %0d dones left, want 0 0", exp_req.size(), exp_done.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
